ram_stream_reader: RTL and testbench
====================================

# ram_stream_reader

Read-side engine for the simple dual-port RAM: on a start command it walks a contiguous address range through the RAM read port (read address plus read enable, one-cycle registered read latency) and delivers the words as a valid/ready stream with a last marker. It is the consumer counterpart to the RAM write path. It sits in the read clock domain, between the RAM and any downstream consumer such as a serializer or output port.

## Interface
Parameters:
- DEPTH_LOG2, default ADDR_WIDTH: address width of the RAM being read.
- BUF_DEPTH, default 4: output skid-buffer entries, minimum 3.

Ports:
- clk  in  1  single clock, rising edge; same clock as the RAM read port.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  command pulse; sampled only in IDLE.
- base_addr  in  ADDR_W  first address of the range; captured on start.
- length  in  ADDR_WIDTH+1  number of words to read; captured on start.
- en_r  out  1  RAM read enable.
- read_addr  out  ADDR_W  RAM read address.
- ram_out  in  DATA_W  RAM read data; valid one cycle after en_r.
- data_out  out  DATA_W  stream data.
- valid_out  out  1  stream valid.
- ready_in  in  1  stream ready from the consumer.
- last_out  out  1  marks the final word; qualified by valid_out.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the final word is accepted, or for an empty command.

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE: on start with length > 0, capture the command and move to READ. On start with length = 0, pulse done the next cycle and stay in IDLE. No en_r is issued for an empty command.
- READ: assert en_r and read_addr only while issue credits exist. Credits = BUF_DEPTH − occupancy − reads in flight. Each issue increments the address and decrements the remaining count. After the last issue, move to DRAIN.
- DRAIN: wait until the buffer is empty and the last word has been accepted, then pulse done and return to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH: a range that passes the top address wraps to 0.
- Stream rules:
  - A word transfers when valid_out && ready_in.
  - data_out and last_out are held stable while valid_out && !ready_in.
  - No word is dropped or duplicated.
- A start received while busy is ignored. It is neither queued nor allowed to alter the captured command.
- rst in any state returns the block to IDLE and flushes the buffer and in-flight reads. Data returned by the RAM after rst is discarded.

## Timing
- Reset values: en_r=0, read_addr=0, data_out=0, valid_out=0, last_out=0, busy=0, done=0.
- start sampled at edge N. Then:
  - busy=1 and first en_r in cycle N+1.
  - ram_out is valid in N+2 and is captured into the buffer.
  - valid_out is high in N+3.
- With ready_in held high, throughput is 1 word per clock. An L-word command therefore completes with done in cycle N+L+3.
- last_out and done: last_out accompanies the final word. done pulses in the cycle after that word is accepted. busy falls in the same cycle as done.
- Backpressure: while ready_in=0, en_r stops within BUF_DEPTH words.
- The next start is accepted from the cycle done is high onward.

## Configuration
- READER_ABORT_EN defined:
  - Adds port abort (in, 1).
  - abort in READ or DRAIN immediately stops issuing reads, flushes the buffer and in-flight data, and deasserts valid_out the next cycle.
  - done pulses the next cycle; last_out is never asserted for an aborted command.
  - abort in IDLE has no effect.
- READER_ABORT_EN undefined: no abort port; every command runs to completion or until rst.

## Structure
- Shared DataTypes package holds bit_t, DATA_W, ADDR_W, DATA_WIDTH, ADDR_WIDTH and the reader FSM state enum (IDLE/READ/DRAIN).
- One sub-module, stream_skid_fifo: a synchronous BUF_DEPTH-entry FIFO with occupancy output, used as the output buffer. The FSM, address and length counters and credit logic stay in the top module.

## Test plan
- Reset and idle: rst held 3 cycles → all outputs 0. Then start with length=0 → done=1 exactly one cycle later, en_r never asserted, busy stays 0.
- Basic read:
  - Stimulus: RAM preloaded addr k = 0xA0+k; start with base=4, length=8, ready_in=1.
  - Required response: data 0xA4…0xAB in order, valid_out first in cycle N+3, last_out only on 0xAB, done in cycle N+11.
- Wrap-around: base = 2^ADDR_WIDTH−2, length=4 → read_addr sequence top−1, top, 0, 1; data order matches.
- Backpressure: length=16 with ready_in toggling on a random pattern, including an 8-cycle stall → all 16 words delivered exactly once and in order; data stable during the stall; en_r idle during the stall once the buffer is full.
- Busy start and reset mid-run:
  - A second start during a command is ignored; the word count is unchanged.
  - rst asserted mid-READ → next cycle in IDLE, all outputs 0; a fresh command then returns correct data with no stale words.
- READER_ABORT_EN: abort after 3 words of a 10-word command → valid_out low next cycle, done pulse, last_out never seen, next command correct.

Source files
------------

// File: rtl/ram_stream_reader_pkg.sv
// Shared widths, scalar type and reader FSM encoding for the RAM stream reader.
package ram_stream_reader_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int DATA_W     = DATA_WIDTH;
  localparam int ADDR_W     = ADDR_WIDTH;

  typedef logic bit_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    DRAIN = ST_DRAIN
  } reader_state_e;

endpackage

// File: rtl/ram_stream_reader_stream_skid_fifo.sv
// Synchronous DEPTH-entry FIFO with occupancy output; used as the reader's
// output skid buffer. Head word is presented combinationally, zero when empty.
module stream_skid_fifo
  import ram_stream_reader_pkg::*;
#(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  bit_t             flush,
  input  bit_t             push,
  input  logic [WIDTH-1:0] push_data,
  input  bit_t             pop,
  output logic [WIDTH-1:0] pop_data,
  output bit_t             valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  bit_t             do_push;
  bit_t             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop   = pop && (cnt != '0);
  assign do_push  = push && ((cnt != CNT_W'(DEPTH)) || do_pop);
  assign valid    = (cnt != '0);
  assign count    = cnt;
  assign pop_data = valid ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are live, and the output is zeroed while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a contiguous RAM range through a one-cycle-latency read port and emits
// the words as a valid/ready stream with last. Optional abort: READER_ABORT_EN.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int DEPTH_LOG2 = ADDR_W,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DEPTH_LOG2-1:0] base_addr,
  input  logic [DEPTH_LOG2:0]   length,
  output logic                  en_r,
  output logic [DEPTH_LOG2-1:0] read_addr,
  input  logic [DATA_W-1:0]     ram_out,
  output logic [DATA_W-1:0]     data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
`ifdef READER_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  last_out,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  reader_state_e         state;
  logic [DEPTH_LOG2-1:0] addr;
  logic [DEPTH_LOG2:0]   remaining;
  bit_t                  rd_pending;
  bit_t                  rd_last;
  bit_t                  abort_hit;
  bit_t                  fire;
  logic [CNT_W-1:0]      occupancy;
  logic [CNT_W:0]        used_slots;
  logic [DATA_W:0]       fifo_out;
  bit_t                  fifo_valid;

`ifdef READER_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // A read is issued only if its word is guaranteed a buffer slot, so the
  // buffer can never overflow however long the consumer stalls.
  assign used_slots = {1'b0, occupancy} + {{CNT_W{1'b0}}, rd_pending};
  assign en_r       = (state == READ) && !abort_hit
                      && (used_slots < (CNT_W + 1)'(BUF_DEPTH));
  assign read_addr  = addr;
  assign busy       = (state != IDLE);
  assign valid_out  = fifo_valid;
  assign {last_out, data_out} = fifo_out;
  assign fire       = valid_out && ready_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      rd_pending <= 1'b0;
      rd_last    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      rd_pending <= en_r;
      rd_last    <= en_r && (remaining == (DEPTH_LOG2 + 1)'(1));
      case (state)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              addr      <= base_addr;
              remaining <= length;
              state     <= READ;
            end
          end
        end
        READ: begin
          if (abort_hit) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (en_r) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == (DEPTH_LOG2 + 1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort_hit) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (fire && last_out) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Words still in flight from the RAM when an abort lands are dropped by the
  // flush, which takes priority over the push in the same cycle.
  stream_skid_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort_hit),
    .push      (rd_pending),
    .push_data ({rd_last, ram_out}),
    .pop       (fire),
    .pop_data  (fifo_out),
    .valid     (fifo_valid),
    .count     (occupancy)
  );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: RAM model, queue-based reference
// of the expected word stream, directed and randomized commands.
`timescale 1ns/1ps
module tb_ram_stream_reader;
  import ram_stream_reader_pkg::*;

  localparam int AW     = ADDR_WIDTH;
  localparam int NWORDS = 1 << AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [AW:0]       length;
  logic              en_r;
  logic [AW-1:0]     read_addr;
  logic [DATA_W-1:0] ram_out;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              ready_in;
  logic              last_out;
  logic              busy;
  logic              done;
`ifdef READER_ABORT_EN
  logic              abort;
`endif

  always #5 clk = ~clk;

  ram_stream_reader #(.DEPTH_LOG2(AW), .BUF_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .en_r      (en_r),
    .read_addr (read_addr),
    .ram_out   (ram_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
`ifdef READER_ABORT_EN
    .abort     (abort),
`endif
    .last_out  (last_out),
    .busy      (busy),
    .done      (done)
  );

  // RAM read port with one cycle of registered latency
  logic [DATA_W-1:0] mem [NWORDS];
  always @(posedge clk) if (en_r) ram_out <= mem[read_addr];

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   addr_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   first_valid, done_cyc, done_cnt, words, en_cnt, last_cnt, cmd_start;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic prev_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Inputs are already set for the coming edge: score the transfer it will
  // perform, then advance to the next falling edge and observe.
  task automatic cycle();
    exp_t e;
    if (!rst && valid_out && ready_in) begin
      words++;
      if (exp_q.size() == 0) check("extra_word", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("data", data_out, e.data);
        check("last", last_out, e.last);
      end
    end
    prev_stall = !rst && valid_out && !ready_in;
    prev_data  = data_out;
    prev_last  = last_out;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (prev_stall) begin
        check("stall_valid", valid_out, 1);
        check("stall_data", data_out, prev_data);
        check("stall_last", last_out, prev_last);
      end
      if (en_r) begin
        en_cnt++;
        addr_q.push_back(int'(read_addr));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (valid_out && first_valid < 0) first_valid = cyc;
      if (valid_out && last_out) last_cnt++;
    end
  endtask

  task automatic clear_stats();
    first_valid = -1; done_cyc = -1; done_cnt = 0; words = 0;
    en_cnt = 0; last_cnt = 0; addr_q.delete();
  endtask

  // mode 0: ready high; 1: random ready; 2: random ready with an 8-cycle stall;
  // 3: ready high plus a second start while busy.
  task automatic run_cmd(input int b, input int len, input int mode);
    bit stall;
    for (int i = 0; i < len; i++)
      exp_q.push_back('{last: (i == len - 1), data: mem[(b + i) % NWORDS]});
    clear_stats();
    base_addr = AW'(b);
    length    = (AW + 1)'(len);
    start     = 1'b1;
    cmd_start = cyc;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 400 && done_cnt == 0; k++) begin
      stall = (mode == 2) && (k >= 6) && (k < 14);
      if (mode == 1 || mode == 2) ready_in = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      else ready_in = 1'b1;
      if (mode == 3 && k == 2) begin
        start     = 1'b1;
        base_addr = AW'(b + 5);
        length    = (AW + 1)'(3);
      end else begin
        start = 1'b0;
      end
      cycle();
      if (stall && k >= 10) check("stall_en_r", en_r, 0);
    end
    start    = 1'b0;
    ready_in = 1'b1;
    check("done_seen", done_cnt, 1);
    check("word_count", words, len);
    check("queue_empty", exp_q.size(), 0);
    check("busy_at_done", busy, 0);
    cycle();
    check("done_width", done, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_en_r"}, en_r, 0);
    check({tag, "_read_addr"}, read_addr, 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_valid_out"}, valid_out, 0);
    check({tag, "_last_out"}, last_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; ready_in = 1'b1;
`ifdef READER_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < NWORDS; i++) mem[i] = DATA_W'(8'hA0 + i);
    clear_stats();

    // Reset and empty command
    repeat (3) cycle();
    check_idle_outputs("reset");
    rst = 1'b0;
    cycle();
    clear_stats();
    length = '0; start = 1'b1;
    cycle();
    start = 1'b0;
    check("empty_done", done, 1);
    check("empty_busy", busy, 0);
    cycle();
    check("empty_done_clear", done, 0);
    repeat (3) cycle();
    check("empty_no_en_r", en_cnt, 0);
    check("empty_busy_after", busy, 0);

    // Basic read with latency and completion timing
    run_cmd(4, 8, 0);
    check("basic_first_valid", first_valid - cmd_start, 3);
    check("basic_done_cycle", done_cyc - cmd_start, 11);
    check("basic_last_count", last_cnt, 1);
    check("basic_first_addr", addr_q.size() > 0 ? addr_q[0] : -1, 4);

    // Wrap-around past the top address
    run_cmd(NWORDS - 2, 4, 0);
    check("wrap_addr_count", addr_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check("wrap_addr", i < addr_q.size() ? addr_q[i] : -1, (NWORDS - 2 + i) % NWORDS);

    // Backpressure with a long stall
    run_cmd(3, 16, 2);

    // Start while busy is ignored
    run_cmd(6, 7, 3);

    // Reset in the middle of a read
    for (int i = 0; i < 10; i++) exp_q.push_back('{last: (i == 9), data: mem[i]});
    clear_stats();
    base_addr = '0; length = (AW + 1)'(10); start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    rst = 1'b1;
    cycle();
    check_idle_outputs("midrst");
    rst = 1'b0;
    exp_q.delete();
    run_cmd(2, 6, 0);

`ifdef READER_ABORT_EN
    for (int i = 0; i < 10; i++) exp_q.push_back('{last: (i == 9), data: mem[(1 + i) % NWORDS]});
    clear_stats();
    base_addr = AW'(1); length = (AW + 1)'(10); start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 50 && words < 3; k++) cycle();
    ready_in = 1'b0; abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_valid", valid_out, 0);
    check("abort_done", done, 1);
    check("abort_busy", busy, 0);
    check("abort_words", words, 3);
    check("abort_no_last", last_cnt, 0);
    ready_in = 1'b1;
    exp_q.delete();
    cycle();
    run_cmd(5, 6, 0);
`endif

    // Randomized commands over random RAM contents
    for (int i = 0; i < NWORDS; i++) mem[i] = DATA_W'($urandom);
    for (int t = 0; t < 8; t++)
      run_cmd(int'($urandom_range(0, NWORDS - 1)), int'($urandom_range(1, NWORDS)), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
